fir_frame_arbiter: RTL and testbench
====================================

Name: fir_frame_arbiter

Overview:
- Shares one fir_15 instance between NUM_CH independent AXI-Stream sample sources.
- Grants the FIR one whole frame at a time using a round-robin policy, and forwards that frame to the FIR.
- Tags the FIR's returning output with the granted channel ID.
- Holds off the next grant until the FIR has flushed the current frame (return beat with tlast), so frames never mix inside the filter pipeline.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- DATA_W, 32, sample width, matches the FIR's TDATA width
- CH_W, $clog2(NUM_CH), channel-ID width
- DRAIN_TIMEOUT, 64, idle cycles allowed in DRAIN before forced release

Ports:
- s00_axis_aclk  in  1  sole clock
- s00_axis_aresetn  in  1  reset; asynchronous, active-low
- s00_axis_tvalid  in  NUM_CH  per-channel source valid
- s00_axis_tdata  in  NUM_CH*DATA_W  per-channel data; channel i occupies [i*DATA_W +: DATA_W]
- s00_axis_tlast  in  NUM_CH  per-channel end of frame
- s00_axis_tready  out  NUM_CH  per-channel ready
- m00_axis_tvalid/tready/tdata/tlast/tstrb  out/in/out/out/out  1/1/DATA_W/1/DATA_W/8  stream into the FIR
- s01_axis_tvalid/tready/tdata/tlast  in/out/in/in  1/1/DATA_W/1  stream returning from the FIR
- m01_axis_tvalid/tready/tdata/tlast/tdest  out/in/out/out/out  1/1/DATA_W/1/CH_W  tagged output stream
- cur_ch  out  CH_W  channel currently granted
- busy  out  1  high whenever state != IDLE
- frame_count  out  16  number of completed frames; wraps at 16 bits
- stray_err  out  1  one-cycle pulse when a FIR beat is discarded in IDLE
- drain_timeout  out  1  one-cycle pulse when DRAIN is force-released

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE; rr_ptr=0; cur_ch=0; frame_count=0; ret_done=0; timer=0.
  - All tready and tvalid outputs 0; stray_err=0; drain_timeout=0.
- FSM IDLE:
  - If any s00_axis_tvalid bit is set, grant the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_CH.
  - Register cur_ch=grant, set rr_ptr=grant+1 (mod NUM_CH), go to FORWARD.
  - Grant takes 1 cycle; no data is forwarded in IDLE.
- FSM FORWARD:
  - Combinational pass-through: m00_tvalid=s00_tvalid[cur_ch]; m00_tdata/tlast come from cur_ch; s00_tready[cur_ch]=m00_tready; all other tready bits 0.
  - m00_tstrb is all ones.
  - On an accepted beat with tlast: if ret_done, go to IDLE; otherwise go to DRAIN.
- FSM DRAIN:
  - m00_tvalid=0; all s00_tready=0.
  - When a return beat with tlast is accepted, go to IDLE.
  - timer increments on each cycle with no accepted return beat and clears on any accepted return beat.
  - When timer reaches DRAIN_TIMEOUT-1: pulse drain_timeout, go to IDLE.
- Return path in FORWARD and DRAIN:
  - m01_tvalid=s01_tvalid; s01_tready=m01_tready; tdata/tlast pass through; m01_tdest=cur_ch.
  - Zero added latency.
  - A return tlast accepted while still in FORWARD sets ret_done; ret_done clears on entry to IDLE.
- Return path in IDLE: s01_tready=1, m01_tvalid=0; any accepted beat is discarded and pulses stray_err.
- Frame completion: frame_count increments by 1 on every FORWARD/DRAIN -> IDLE transition, including timeouts.
- Single-beat frame: tlast on the first beat moves FORWARD -> DRAIN on that same accepted beat.
- A channel dropping tvalid mid-frame: the grant is held; the arbiter waits indefinitely in FORWARD.
- Backpressure: m01_tready=0 stalls the FIR return only; the input side continues while m00_tready allows.

Decomposition:
- Package fir_arb_pkg:
  - state enum {IDLE, FORWARD, DRAIN}
  - DATA_W and NUM_CH defaults
  - function rr_pick(req, ptr) returning {found, idx}
- Sub-module rr_arbiter (NUM_CH): req vector plus ptr in, grant index plus valid out; purely combinational.
- Pointer register and FSM stay in the top level.

Test Plan:
- Ch2 only, 4-beat frame 1,2,3,4; FIR model returns 5 beats ending in tlast -> m00 sees 1,2,3,4 with tlast on beat 4; m01 gives 5 beats with tdest=2; frame_count=1; busy low after the final beat.
- Ch0, ch1 and ch3 all valid at the same time with rr_ptr=0 -> grant order 0, 1, 3, 0; channels not granted see tready=0 for the whole frame; no interleaving on m00.
- Ch1 single-beat frame (tlast on beat 1) -> FORWARD->DRAIN in one accepted cycle; the next grant happens only after the return tlast.
- Return model never asserts tlast -> drain_timeout pulses exactly 64 cycles after the last return beat; state returns to IDLE; frame_count increments.
- Inject a FIR beat while in IDLE -> s01_tready=1, m01_tvalid stays 0, stray_err pulses for 1 cycle.
- Assert reset on beat 2 of a 5-beat ch3 frame, then release -> all outputs 0, state IDLE, rr_ptr=0; the next request from ch1 is granted with cur_ch=1.

Source files
------------

// File: rtl/fir_arb_pkg.sv
// Shared types and the round-robin pick helper for the FIR frame arbiter.
// The pick helper works on a fixed 8-wide request vector so one function serves every channel count.
package fir_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    DRAIN   = 2'd2
  } arb_state_e;

  localparam int NUM_CH_DEF = 4;
  localparam int DATA_W_DEF = 32;
  localparam int RR_MAX     = 8;

  // Returns {found, idx}: first set request scanning ptr, ptr+1, ... modulo n.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        ptr,
                                         input logic [3:0]        n);
    logic [3:0] res;
    logic [3:0] pos;
    res = 4'd0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      pos = {1'b0, ptr} + k[3:0];
      if (pos >= n) begin
        pos = pos - n;
      end else begin
        pos = pos;
      end
      if ((k[3:0] < n) && !res[3] && req[pos[2:0]]) begin
        res = {1'b1, pos[2:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: picks the first requester at or after ptr.
module rr_arbiter
  import fir_arb_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   grant,
  output logic              grant_valid
);

  logic [RR_MAX-1:0] req_pad_s;
  logic [2:0]        ptr_pad_s;
  logic [3:0]        pick_s;

  // Widen the request/pointer to the helper's fixed width and run the pick.
  always_comb begin
    req_pad_s               = {RR_MAX{1'b0}};
    req_pad_s[NUM_CH-1:0]   = req;
    ptr_pad_s               = 3'(ptr);
    pick_s                  = rr_pick(req_pad_s, ptr_pad_s, 4'(NUM_CH));
  end

  assign grant       = CH_W'(pick_s[2:0]);
  assign grant_valid = pick_s[3];

endmodule

// File: rtl/fir_frame_arbiter.sv
// Shares one FIR between NUM_CH AXI-Stream sources, one whole frame at a time,
// tagging the FIR's returning stream with the granted channel.
module fir_frame_arbiter
  import fir_arb_pkg::*;
#(
  parameter int NUM_CH        = NUM_CH_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int CH_W          = $clog2(NUM_CH),
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                     s00_axis_aclk,
  input  logic                     s00_axis_aresetn,
  input  logic [NUM_CH-1:0]        s00_axis_tvalid,
  input  logic [NUM_CH*DATA_W-1:0] s00_axis_tdata,
  input  logic [NUM_CH-1:0]        s00_axis_tlast,
  output logic [NUM_CH-1:0]        s00_axis_tready,
  output logic                     m00_axis_tvalid,
  input  logic                     m00_axis_tready,
  output logic [DATA_W-1:0]        m00_axis_tdata,
  output logic                     m00_axis_tlast,
  output logic [DATA_W/8-1:0]      m00_axis_tstrb,
  input  logic                     s01_axis_tvalid,
  output logic                     s01_axis_tready,
  input  logic [DATA_W-1:0]        s01_axis_tdata,
  input  logic                     s01_axis_tlast,
  output logic                     m01_axis_tvalid,
  input  logic                     m01_axis_tready,
  output logic [DATA_W-1:0]        m01_axis_tdata,
  output logic                     m01_axis_tlast,
  output logic [CH_W-1:0]          m01_axis_tdest,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     busy,
  output logic [15:0]              frame_count,
  output logic                     stray_err,
  output logic                     drain_timeout
);

  localparam int                  TIMER_W    = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CH_W-1:0]     CH_LAST    = CH_W'(NUM_CH - 1);

  arb_state_e         state_r, next_state_s;
  logic [CH_W-1:0]    rr_ptr_r, cur_ch_r, grant_s;
  logic               grant_valid_s;
  logic [15:0]        frame_count_r;
  logic               ret_done_r, stray_err_r, drain_timeout_r, run_r;
  logic [TIMER_W-1:0] timer_r;
  logic               sel_tvalid_s, sel_tlast_s;
  logic               m00_tvalid_s, m00_tlast_s;
  logic [NUM_CH-1:0]  s00_tready_s;
  logic               s01_tready_s, m01_tvalid_s;
  logic               ret_acc_s, ret_last_s, timeout_s, frame_done_s;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr (
    .req         (s00_axis_tvalid),
    .ptr         (rr_ptr_r),
    .grant       (grant_s),
    .grant_valid (grant_valid_s)
  );

  assign sel_tvalid_s = s00_axis_tvalid[cur_ch_r];
  assign sel_tlast_s  = s00_axis_tlast[cur_ch_r];

  // Return path: owned by the granted frame outside IDLE, swallowed in IDLE.
  always_comb begin
    s01_tready_s = 1'b0;
    m01_tvalid_s = 1'b0;
    case (state_r)
      IDLE: begin
        s01_tready_s = run_r;
        m01_tvalid_s = 1'b0;
      end
      FORWARD, DRAIN: begin
        s01_tready_s = m01_axis_tready;
        m01_tvalid_s = s01_axis_tvalid;
      end
      default: begin
        s01_tready_s = 1'b0;
        m01_tvalid_s = 1'b0;
      end
    endcase
  end

  assign ret_acc_s  = s01_axis_tvalid & s01_tready_s;
  assign ret_last_s = ret_acc_s & s01_axis_tlast;

  // Next-state and input-side forwarding.
  always_comb begin
    next_state_s = state_r;
    m00_tvalid_s = 1'b0;
    m00_tlast_s  = 1'b0;
    s00_tready_s = {NUM_CH{1'b0}};
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          next_state_s = FORWARD;
        end else begin
          next_state_s = IDLE;
        end
      end
      FORWARD: begin
        m00_tvalid_s           = sel_tvalid_s;
        m00_tlast_s            = sel_tlast_s;
        s00_tready_s[cur_ch_r] = m00_axis_tready;
        if (sel_tvalid_s && m00_axis_tready && sel_tlast_s) begin
          // FIR already flushed this frame: nothing left to drain.
          if (ret_done_r || ret_last_s) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = DRAIN;
          end
        end else begin
          next_state_s = FORWARD;
        end
      end
      DRAIN: begin
        if (ret_last_s) begin
          next_state_s = IDLE;
        end else if (!ret_acc_s && (timer_r == TIMER_LAST)) begin
          next_state_s = IDLE;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = DRAIN;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  assign frame_done_s = (state_r != IDLE) && (next_state_s == IDLE);

  // FSM, grant and round-robin pointer registers.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_r  <= IDLE;
      rr_ptr_r <= {CH_W{1'b0}};
      cur_ch_r <= {CH_W{1'b0}};
      run_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      run_r   <= 1'b1;
      if ((state_r == IDLE) && grant_valid_s) begin
        cur_ch_r <= grant_s;
        rr_ptr_r <= (grant_s == CH_LAST) ? {CH_W{1'b0}} : grant_s + CH_W'(1);
      end else begin
        cur_ch_r <= cur_ch_r;
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Frame bookkeeping: early-return flag, drain timer, counters and pulses.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      ret_done_r      <= 1'b0;
      timer_r         <= {TIMER_W{1'b0}};
      frame_count_r   <= 16'd0;
      stray_err_r     <= 1'b0;
      drain_timeout_r <= 1'b0;
    end else begin
      if (next_state_s == IDLE) begin
        ret_done_r <= 1'b0;
      end else if ((state_r == FORWARD) && ret_last_s) begin
        ret_done_r <= 1'b1;
      end else begin
        ret_done_r <= ret_done_r;
      end
      if ((state_r != DRAIN) || ret_acc_s) begin
        timer_r <= {TIMER_W{1'b0}};
      end else begin
        timer_r <= timer_r + TIMER_W'(1);
      end
      if (frame_done_s) begin
        frame_count_r <= frame_count_r + 16'd1;
      end else begin
        frame_count_r <= frame_count_r;
      end
      stray_err_r     <= (state_r == IDLE) && ret_acc_s;
      drain_timeout_r <= timeout_s;
    end
  end

  assign s00_axis_tready = s00_tready_s;
  assign m00_axis_tvalid = m00_tvalid_s;
  assign m00_axis_tdata  = s00_axis_tdata[cur_ch_r*DATA_W +: DATA_W];
  assign m00_axis_tlast  = m00_tlast_s;
  assign m00_axis_tstrb  = {(DATA_W/8){1'b1}};
  assign s01_axis_tready = s01_tready_s;
  assign m01_axis_tvalid = m01_tvalid_s;
  assign m01_axis_tdata  = s01_axis_tdata;
  assign m01_axis_tlast  = s01_axis_tlast;
  assign m01_axis_tdest  = cur_ch_r;
  assign cur_ch          = cur_ch_r;
  assign busy            = (state_r != IDLE);
  assign frame_count     = frame_count_r;
  assign stray_err       = stray_err_r;
  assign drain_timeout   = drain_timeout_r;

endmodule

// File: tb/tb_fir_frame_arbiter.sv
// Directed bench for fir_frame_arbiter; expected beats go through scoreboard queues.
module tb_fir_frame_arbiter;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int CH_W   = 2;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  dest;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        s00_tvalid, s00_tlast, s00_tready;
  logic [NUM_CH*DATA_W-1:0] s00_tdata;
  logic                     m00_tvalid, m00_tready, m00_tlast;
  logic [DATA_W-1:0]        m00_tdata;
  logic [DATA_W/8-1:0]      m00_tstrb;
  logic                     s01_tvalid, s01_tready, s01_tlast;
  logic [DATA_W-1:0]        s01_tdata;
  logic                     m01_tvalid, m01_tready, m01_tlast;
  logic [DATA_W-1:0]        m01_tdata;
  logic [CH_W-1:0]          m01_tdest, cur_ch;
  logic                     busy, stray_err, drain_timeout;
  logic [15:0]              frame_count;

  int    checks = 0;
  int    errors = 0;
  int    tcount;
  beat_t q_m00[$];
  beat_t q_m01[$];
  beat_t mon_e;

  fir_frame_arbiter dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (s00_tvalid),
    .s00_axis_tdata   (s00_tdata),
    .s00_axis_tlast   (s00_tlast),
    .s00_axis_tready  (s00_tready),
    .m00_axis_tvalid  (m00_tvalid),
    .m00_axis_tready  (m00_tready),
    .m00_axis_tdata   (m00_tdata),
    .m00_axis_tlast   (m00_tlast),
    .m00_axis_tstrb   (m00_tstrb),
    .s01_axis_tvalid  (s01_tvalid),
    .s01_axis_tready  (s01_tready),
    .s01_axis_tdata   (s01_tdata),
    .s01_axis_tlast   (s01_tlast),
    .m01_axis_tvalid  (m01_tvalid),
    .m01_axis_tready  (m01_tready),
    .m01_axis_tdata   (m01_tdata),
    .m01_axis_tlast   (m01_tlast),
    .m01_axis_tdest   (m01_tdest),
    .cur_ch           (cur_ch),
    .busy             (busy),
    .frame_count      (frame_count),
    .stray_err        (stray_err),
    .drain_timeout    (drain_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: pops expected beats on every handshake at the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m00_tvalid && m00_tready) begin
        if (q_m00.size() == 0) begin
          check("m00_unexpected_beat", m00_tvalid, 0);
        end else begin
          mon_e = q_m00.pop_front();
          check("m00_data", m00_tdata, mon_e.data);
          check("m00_last", m00_tlast, mon_e.last);
          check("m00_tstrb", m00_tstrb, 4'hF);
        end
      end
      if (m01_tvalid && m01_tready) begin
        if (q_m01.size() == 0) begin
          check("m01_unexpected_beat", m01_tvalid, 0);
        end else begin
          mon_e = q_m01.pop_front();
          check("m01_data", m01_tdata, mon_e.data);
          check("m01_last", m01_tlast, mon_e.last);
          check("m01_tdest", m01_tdest, mon_e.dest);
        end
      end
    end
  end

  task automatic send_beat(input int ch, input logic [31:0] data, input logic last);
    beat_t b;
    int    waited;
    s00_tvalid[ch]                  = 1'b1;
    s00_tdata[ch*DATA_W +: DATA_W]  = data;
    s00_tlast[ch]                   = last;
    b.data = data; b.last = last; b.dest = 2'd0;
    q_m00.push_back(b);
    waited = 0;
    @(negedge clk);
    while (!s00_tready[ch] && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("src_handshake_in_time", waited < 200, 1);
    check("other_tready_low", s00_tready & ~(4'b0001 << ch), 0);
    @(posedge clk); #1;
  endtask

  task automatic end_frame(input int ch);
    s00_tvalid[ch] = 1'b0;
    s00_tlast[ch]  = 1'b0;
  endtask

  task automatic send_ret(input logic [31:0] data, input logic last, input logic [1:0] dest);
    beat_t b;
    int    waited;
    s01_tvalid = 1'b1;
    s01_tdata  = data;
    s01_tlast  = last;
    b.data = data; b.last = last; b.dest = dest;
    q_m01.push_back(b);
    waited = 0;
    @(negedge clk);
    while (!s01_tready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("ret_handshake_in_time", waited < 200, 1);
    @(posedge clk); #1;
    s01_tvalid = 1'b0;
    s01_tlast  = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    s00_tvalid = '0; s00_tlast = '0; s00_tdata = '0;
    m00_tready = 1'b1; m01_tready = 1'b1;
    s01_tvalid = 1'b0; s01_tlast = 1'b0; s01_tdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s00_tready", s00_tready, 0);
    check("rst_m00_tvalid", m00_tvalid, 0);
    check("rst_s01_tready", s01_tready, 0);
    check("rst_m01_tvalid", m01_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_cur_ch", cur_ch, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_pulses", {stray_err, drain_timeout}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Channels 0, 1, 3 contend from rr_ptr=0: grants 0, 1, 3, 0
    s00_tvalid[1] = 1'b1; s00_tdata[1*DATA_W +: DATA_W] = 32'h1100;
    s00_tvalid[3] = 1'b1; s00_tdata[3*DATA_W +: DATA_W] = 32'h3300;
    send_beat(0, 32'h0A00, 1'b0);
    send_beat(0, 32'h0A01, 1'b1);
    s00_tlast[0] = 1'b0; s00_tdata[0*DATA_W +: DATA_W] = 32'h0A10;
    send_ret(32'hF000, 1'b1, 2'd0);
    send_beat(1, 32'h1100, 1'b0);
    send_beat(1, 32'h1101, 1'b1);
    end_frame(1);
    send_ret(32'hF001, 1'b1, 2'd1);
    send_beat(3, 32'h3300, 1'b0);
    send_beat(3, 32'h3301, 1'b1);
    end_frame(3);
    send_ret(32'hF003, 1'b1, 2'd3);
    send_beat(0, 32'h0A10, 1'b0);
    send_beat(0, 32'h0A11, 1'b1);
    end_frame(0);
    send_ret(32'hF010, 1'b1, 2'd0);
    check("rr_frame_count", frame_count, 4);

    // Ch2 alone, 4-beat frame with initial m00 backpressure, 5-beat return
    m00_tready = 1'b0;
    s00_tvalid[2] = 1'b1; s00_tdata[2*DATA_W +: DATA_W] = 32'd1; s00_tlast[2] = 1'b0;
    @(negedge clk); @(negedge clk);
    check("bp_cur_ch", cur_ch, 2);
    check("bp_m00_tvalid", m00_tvalid, 1);
    check("bp_s00_tready", s00_tready, 0);
    @(posedge clk); #1;
    m00_tready = 1'b1;
    for (int i = 1; i <= 4; i++) send_beat(2, 32'(i), i == 4);
    end_frame(2);
    check("ch2_drain_busy", busy, 1);
    m01_tready = 1'b0;
    s01_tvalid = 1'b1; s01_tdata = 32'h100;
    @(negedge clk);
    check("m01_bp_s01_tready", s01_tready, 0);
    check("m01_bp_m01_tvalid", m01_tvalid, 1);
    @(posedge clk); #1;
    m01_tready = 1'b1;
    for (int i = 0; i < 5; i++) send_ret(32'h100 + 32'(i), i == 4, 2'd2);
    check("ch2_busy_after_last", busy, 0);
    check("ch2_frame_count", frame_count, 5);

    // Ch1 single-beat frame; ch0 must wait for the return tlast
    send_beat(1, 32'h51, 1'b1);
    end_frame(1);
    s00_tvalid[0] = 1'b1; s00_tdata[0*DATA_W +: DATA_W] = 32'h61; s00_tlast[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("single_hold_busy", busy, 1);
      check("single_hold_cur_ch", cur_ch, 1);
      check("single_hold_tready", s00_tready, 0);
      check("single_hold_m00_tvalid", m00_tvalid, 0);
    end
    @(posedge clk); #1;
    send_ret(32'h71, 1'b1, 2'd1);
    check("single_idle_after_ret", busy, 0);
    send_beat(0, 32'h61, 1'b1);
    end_frame(0);
    check("single_next_cur_ch", cur_ch, 0);
    send_ret(32'h72, 1'b1, 2'd0);
    check("single_frame_count", frame_count, 7);

    // Ch3 drops tvalid mid-frame; return tlast arrives while still forwarding
    send_beat(3, 32'h81, 1'b0);
    send_beat(3, 32'h82, 1'b0);
    end_frame(3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_busy", busy, 1);
      check("stall_cur_ch", cur_ch, 3);
    end
    @(posedge clk); #1;
    send_ret(32'h91, 1'b1, 2'd3);
    check("early_ret_busy", busy, 1);
    send_beat(3, 32'h83, 1'b1);
    end_frame(3);
    check("early_ret_direct_idle", busy, 0);
    check("early_ret_frame_count", frame_count, 8);

    // Ch2 frame whose return never ends: drain timeout
    send_beat(2, 32'hA1, 1'b0);
    send_beat(2, 32'hA2, 1'b1);
    end_frame(2);
    send_ret(32'hB1, 1'b0, 2'd2);
    send_ret(32'hB2, 1'b0, 2'd2);
    tcount = 0;
    while (tcount < 200) begin
      @(negedge clk);
      if (drain_timeout) break;
      tcount++;
    end
    check("timeout_latency", tcount, 64);
    check("timeout_busy", busy, 0);
    check("timeout_frame_count", frame_count, 9);
    @(negedge clk);
    check("timeout_one_cycle", drain_timeout, 0);

    // Stray FIR beat while idle
    @(posedge clk); #1;
    s01_tvalid = 1'b1; s01_tdata = 32'hDEAD; s01_tlast = 1'b1;
    @(negedge clk);
    check("stray_s01_tready", s01_tready, 1);
    check("stray_m01_tvalid", m01_tvalid, 0);
    @(posedge clk); #1;
    s01_tvalid = 1'b0; s01_tlast = 1'b0;
    @(negedge clk);
    check("stray_pulse", stray_err, 1);
    @(negedge clk);
    check("stray_pulse_end", stray_err, 0);
    check("stray_frame_count", frame_count, 9);

    // Reset on beat 2 of a ch3 frame, then ch1 gets the next grant
    @(posedge clk); #1;
    send_beat(3, 32'hC1, 1'b0);
    s00_tdata[3*DATA_W +: DATA_W] = 32'hC2;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_cur_ch", cur_ch, 0);
    check("midrst_frame_count", frame_count, 0);
    check("midrst_s00_tready", s00_tready, 0);
    check("midrst_m00_tvalid", m00_tvalid, 0);
    check("midrst_s01_tready", s01_tready, 0);
    check("midrst_m01_tvalid", m01_tvalid, 0);
    end_frame(3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_beat(1, 32'hD1, 1'b1);
    end_frame(1);
    check("postrst_cur_ch", cur_ch, 1);
    send_ret(32'hE1, 1'b1, 2'd1);
    check("postrst_frame_count", frame_count, 1);

    check("q_m00_drained", q_m00.size(), 0);
    check("q_m01_drained", q_m01.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
